case_1_mul_share_arb: RTL and testbench
=======================================

Name: case_1_mul_share_arb

Overview:
Round-robin arbiter that time-shares one combinational signed multiplier core (5s x 5s -> 5) among NREQ requesters using valid/ready handshakes. At most one operand pair is granted per cycle. The product is captured in a one-entry output register tagged with the requester index. The block sits between the HLS-generated loop datapaths and the single shared multiplier instance, replacing per-loop multiplier copies.

Parameters:
NREQ, 4, number of requesters (2..8)
DIN0_W, 5, operand-0 width, signed
DIN1_W, 5, operand-1 width, signed
DOUT_W, 5, result width; product truncated to the low DOUT_W bits
ID_W, 2, requester-index width, equal to clog2(NREQ)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_din0  in  NREQ*DIN0_W  packed operand 0; requester i uses slice [i*DIN0_W +: DIN0_W]
req_din1  in  NREQ*DIN1_W  packed operand 1, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accept
rsp_dout  out  DOUT_W  signed product, truncated
rsp_id  out  ID_W  index of the requester that owns rsp_dout
ap_idle  out  1  high when rsp_valid=0 and no req_valid is asserted

Behaviour:
- Clock and reset: single clock, ap_clk. Reset is synchronous and active-high on ap_rst.
- Reset values: rsp_valid=0, rsp_dout=0, rsp_id=0, last_grant=NREQ-1. After reset, requester 0 has top priority.
- FSM, 2 states:
  - EMPTY: output register holds nothing.
  - FULL: rsp_valid=1.
- Accept condition: can_accept = (state==EMPTY) | rsp_ready.
- Grant: combinational round-robin search over req_valid.
  - Search starts at last_grant+1 mod NREQ.
  - req_ready[g]=1 only for the winner g, and only when can_accept.
  - req_ready is never asserted for a requester whose req_valid=0.
- Transfer: on a cycle with req_valid[g] & req_ready[g]:
  - Capture the product of slice g into rsp_dout; rsp_id<=g; last_grant<=g.
  - Next state is FULL.
- Drain: on a cycle with rsp_valid & rsp_ready and no new grant, next state is EMPTY.
- Simultaneous drain and grant: the register is overwritten and state stays FULL. This gives one result per cycle.
- Stall: in FULL with rsp_ready=0:
  - All req_ready=0.
  - rsp_dout and rsp_id hold stable.
  - last_grant is unchanged.
- Latency: request accepted in cycle T gives rsp_valid in cycle T+1. Sustained throughput is 1 per cycle.
- Arithmetic:
  - Both operands are sign-extended to DIN0_W+DIN1_W bits and multiplied as signed.
  - The low DOUT_W bits are kept, with two's-complement wrap and no saturation.
- Fairness:
  - A continuously asserted req_valid is granted within NREQ accepted transfers.
  - last_grant updates only on an actual transfer.
- Requesters may drop req_valid without a grant; the arbiter holds no state for them.
- Reset mid-operation: a pending result is discarded with no rsp_valid pulse, and priority returns to requester 0.
- ap_idle is combinational from rsp_valid and req_valid.

Decomposition:
- Shared package holds:
  - the NREQ/ID_W defaults
  - the operand/result width constants
  - the FSM state encoding (EMPTY=1'b0, FULL=1'b1)
- Natural sub-module: case_1_rr_pick.
  - Inputs: req_valid and last_grant.
  - Outputs: a one-hot grant and an encoded index.
- The multiplier stays a separate combinational core instantiated once, with its din0/din1 muxed by the encoded index.

Test Plan:
- Single request: after reset, req 0 sends din0=3, din1=-2 with rsp_ready=1 -> one cycle later rsp_valid=1, rsp_dout=5'h1A (-6), rsp_id=0.
- Overflow wrap: req 2 sends 7*7 -> rsp_dout=5'b10001 (-15). Then -16*-16 -> rsp_dout=0, rsp_id=2.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows one cycle later; one result per cycle.
- Backpressure: rsp_ready low for 3 cycles while FULL with reqs 1 and 3 valid -> all req_ready=0, rsp_dout/rsp_id stable. When rsp_ready rises, req 1 is granted that same cycle.
- Reset mid-operation: assert ap_rst while FULL and reqs valid -> next cycle rsp_valid=0, req_ready=0. After release, req 0 has priority over req 3 when both are valid.
- Idle and drop: req 1 raises then drops req_valid while the arbiter is stalled -> no transfer, last_grant unchanged, ap_idle=1 once the output drains.

Source files
------------

// File: rtl/case_1_mul_share_arb_pkg.sv
// case_1_mul_share_arb_pkg: shared widths, requester count and output-register state encoding
package case_1_mul_share_arb_pkg;
   localparam int NREQ_DEF   = 4;
   localparam int ID_W_DEF   = 2;
   localparam int DIN0_W_DEF = 5;
   localparam int DIN1_W_DEF = 5;
   localparam int DOUT_W_DEF = 5;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/case_1_mul_share_arb_mul.sv
// case_1_mul_core: signed multiply on sign-extended operands, result wrapped to DOUT_W bits
module case_1_mul_core
   import case_1_mul_share_arb_pkg::*;
#(
   parameter int DIN0_W = DIN0_W_DEF,
   parameter int DIN1_W = DIN1_W_DEF,
   parameter int DOUT_W = DOUT_W_DEF
) (
   input  logic [DIN0_W-1:0] din0_i,
   input  logic [DIN1_W-1:0] din1_i,
   output logic [DOUT_W-1:0] dout_o
);
   localparam int PW = DIN0_W + DIN1_W;
   logic signed [PW-1:0] a_x, b_x, p;
   always_comb begin
      a_x    = {{DIN1_W{din0_i[DIN0_W-1]}}, din0_i};
      b_x    = {{DIN0_W{din1_i[DIN1_W-1]}}, din1_i};
      p      = a_x * b_x;
      dout_o = p[DOUT_W-1:0];
   end
endmodule

// File: rtl/case_1_mul_share_arb_rr_pick.sv
// case_1_rr_pick: round-robin search over valid, starting just after the last granted index
module case_1_rr_pick
   import case_1_mul_share_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int ID_W = ID_W_DEF
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [ID_W-1:0] last_i,
   output logic [NREQ-1:0] grant_o,
   output logic [ID_W-1:0] idx_o,
   output logic            any_o
);
   logic [ID_W-1:0] c;
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      c       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         c = ID_W'((int'(last_i) + k) % NREQ);
         if (!any_o && valid_i[c]) begin
            any_o      = 1'b1;
            grant_o[c] = 1'b1;
            idx_o      = c;
         end
      end
   end
endmodule

// File: rtl/case_1_mul_share_arb.sv
// case_1_mul_share_arb: round-robin time-sharing of one signed multiplier among NREQ requesters
module case_1_mul_share_arb
   import case_1_mul_share_arb_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int DIN0_W = DIN0_W_DEF,
   parameter int DIN1_W = DIN1_W_DEF,
   parameter int DOUT_W = DOUT_W_DEF,
   parameter int ID_W   = ID_W_DEF
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*DIN0_W-1:0]   req_din0,
   input  logic [NREQ*DIN1_W-1:0]   req_din1,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DOUT_W-1:0]        rsp_dout,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     ap_idle
);
   state_e              state_q, state_d;
   logic [DOUT_W-1:0]   dout_q, dout_d, prod;
   logic [ID_W-1:0]     id_q, id_d, last_q, last_d, idx;
   logic [NREQ-1:0]     grant;
   logic                any, can_accept, xfer;

   case_1_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
      .valid_i(req_valid), .last_i(last_q), .grant_o(grant), .idx_o(idx), .any_o(any)
   );

   case_1_mul_core #(.DIN0_W(DIN0_W), .DIN1_W(DIN1_W), .DOUT_W(DOUT_W)) u_mul (
      .din0_i(req_din0[idx*DIN0_W +: DIN0_W]), .din1_i(req_din1[idx*DIN1_W +: DIN1_W]), .dout_o(prod)
   );

   // reset gating keeps req_ready low while a reset cycle discards everything
   always_comb begin
      can_accept = !ap_rst && (state_q == EMPTY || rsp_ready);
      xfer       = can_accept && any;
      req_ready  = can_accept ? grant : '0;
      state_d    = xfer ? FULL : (rsp_ready ? EMPTY : state_q);
      dout_d     = xfer ? prod : dout_q;
      id_d       = xfer ? idx : id_q;
      last_d     = xfer ? idx : last_q;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= EMPTY;
         dout_q  <= '0;
         id_q    <= '0;
         last_q  <= ID_W'(NREQ - 1);
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   assign rsp_valid = (state_q == FULL);
   assign rsp_dout  = dout_q;
   assign rsp_id    = id_q;
   assign ap_idle   = !rsp_valid && !(|req_valid);
endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// tb_case_1_mul_share_arb: directed and random stimulus checked against a behavioural arbiter model
module tb_case_1_mul_share_arb;
   localparam int N = 4;
   logic        ap_clk = 1'b0, ap_rst = 1'b1;
   logic [3:0]  req_valid = '0, req_ready;
   logic [19:0] req_din0 = '0, req_din1 = '0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [4:0]  rsp_dout;
   logic [1:0]  rsp_id;
   logic        ap_idle;
   int n_chk = 0, n_fail = 0;
   bit m_valid = 0;
   int m_dout = 0, m_id = 0, m_last = N - 1, g = -1;
   int seq [6] = '{0, 1, 2, 3, 0, 1};

   case_1_mul_share_arb dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_din0(req_din0), .req_din1(req_din1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_dout(rsp_dout), .rsp_id(rsp_id), .ap_idle(ap_idle)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      if (ap_rst || (m_valid && !rsp_ready)) return -1;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_last + k) % N;
         if (req_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic set_op(input int i, input int a, input int b);
      req_din0[i*5 +: 5] = a[4:0];
      req_din1[i*5 +: 5] = b[4:0];
   endtask

   // checks outputs mid-cycle, then advances the model across the rising edge
   task automatic cycle();
      int a, b;
      @(negedge ap_clk);
      g = pick();
      chk("req_ready", int'(req_ready), g < 0 ? 0 : (1 << g));
      chk("rsp_valid", int'(rsp_valid), int'(m_valid));
      chk("rsp_dout", int'(rsp_dout), m_dout);
      chk("rsp_id", int'(rsp_id), m_id);
      chk("ap_idle", int'(ap_idle), int'(!m_valid && req_valid == 4'd0));
      @(posedge ap_clk);
      if (ap_rst) begin
         m_valid = 0; m_dout = 0; m_id = 0; m_last = N - 1;
      end else if (g >= 0) begin
         a = $signed(req_din0[g*5 +: 5]);
         b = $signed(req_din1[g*5 +: 5]);
         m_valid = 1; m_dout = (a * b) & 31; m_id = g; m_last = g;
      end else if (rsp_ready) m_valid = 0;
      #1;
   endtask

   initial begin
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      cycle();
      set_op(0, 3, -2); req_valid = 4'b0001; rsp_ready = 1'b1;
      cycle();
      chk("single_dout", int'(rsp_dout), 'h1A);
      chk("single_id", int'(rsp_id), 0);
      set_op(2, 7, 7); req_valid = 4'b0100;
      cycle();
      chk("wrap_pos", int'(rsp_dout), 'b10001);
      set_op(2, -16, -16);
      cycle();
      chk("wrap_neg", int'(rsp_dout), 0);
      chk("wrap_id", int'(rsp_id), 2);
      ap_rst = 1'b1; req_valid = '0;
      cycle();
      ap_rst = 1'b0;
      for (int i = 0; i < N; i++) set_op(i, i + 1, -(i + 2));
      req_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("rr_id", int'(rsp_id), seq[i]);
      end
      req_valid = 4'b0001;
      cycle();
      req_valid = 4'b1010; rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_ready", int'(req_ready), 0);
         chk("bp_id", int'(rsp_id), 0);
      end
      rsp_ready = 1'b1;
      cycle();
      chk("bp_grant", int'(rsp_id), 1);
      req_valid = 4'b1001;
      cycle();
      ap_rst = 1'b1;
      cycle();
      chk("rst_valid", int'(rsp_valid), 0);
      ap_rst = 1'b0;
      cycle();
      chk("rst_prio", int'(rsp_id), 0);
      rsp_ready = 1'b0; req_valid = 4'b0010;
      cycle();
      req_valid = '0;
      cycle();
      rsp_ready = 1'b1;
      cycle();
      chk("drop_idle", int'(ap_idle), 1);
      req_valid = 4'b1111;
      cycle();
      chk("drop_last", int'(rsp_id), 1);
      repeat (300) begin
         ap_rst    = ($urandom_range(0, 49) == 0);
         req_valid = 4'($urandom);
         req_din0  = 20'($urandom);
         req_din1  = 20'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
